// File: rtl/int_ctrl_pkg.sv
// Shared types and limits for the interrupt pending controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package int_ctrl_pkg;

   // Largest source count the controller is sized for.
   localparam int MAX_SOURCES = 16;

   // Delivery FSM: waiting for work, offering to the CPU, handler running.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      SERVICE = 2'd2
   } state_t;

endpackage

// File: rtl/int_priority_select.sv
// Picks one eligible source: lowest index, or round-robin from ptr+1 when
// INT_CTRL_ROUND_ROBIN_EN is defined. Latency: purely combinational.
// Backpressure: none; result is consumed only when the caller decides to load it.
module int_priority_select
   import int_ctrl_pkg::*;
#(
   parameter int N_SOURCES = 4,
   parameter int ID_W      = $clog2(N_SOURCES)
) (
   input  logic [N_SOURCES-1:0] eligible,
   input  logic [ID_W-1:0]      ptr,
   output logic                 found,
   output logic [ID_W-1:0]      idx
);

`ifdef INT_CTRL_ROUND_ROBIN_EN
   // Scan ptr+1 .. ptr+N (wrapping); iterating from the far end lets the
   // nearest eligible source overwrite earlier candidates.
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      idx   = '0;
      for (int k = N_SOURCES; k >= 1; k--) begin
         j = int'(ptr) + k;
         if (j >= N_SOURCES) j = j - N_SOURCES;
         if (eligible[j]) begin
            found = 1'b1;
            idx   = ID_W'(j);
         end
      end
   end
`else
   // Fixed priority: scanning downward leaves the lowest set index in idx.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N_SOURCES - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            found = 1'b1;
            idx   = ID_W'(i);
         end
      end
   end

   // The pointer carries no meaning under fixed priority.
   logic unused_ptr;
   assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/int_pending_controller.sv
// Latches interrupt pulses, offers one source at a time to the CPU, tracks the handler.
// Latency: int_req -> pending 1 cycle, pending -> irq_valid 1 cycle (2 minimum).
// Backpressure: irq_valid/irq_id hold until irq_ack; no new offer until irq_done. Option: INT_CTRL_ROUND_ROBIN_EN.
module int_pending_controller
   import int_ctrl_pkg::*;
#(
   parameter int N_SOURCES = 4,
   parameter int ID_W      = $clog2(N_SOURCES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_SOURCES-1:0] int_req,
   input  logic [N_SOURCES-1:0] int_mask,
   input  logic                 global_int_en,
   output logic                 irq_valid,
   output logic [ID_W-1:0]      irq_id,
   input  logic                 irq_ack,
   input  logic                 irq_done,
   output logic [N_SOURCES-1:0] pending,
   output logic [N_SOURCES-1:0] missed,
   input  logic                 missed_clear,
   output logic                 in_service
);

   state_t                state_q;
   state_t                state_nxt;
   logic [N_SOURCES-1:0]  pending_q;
   logic [N_SOURCES-1:0]  missed_q;
   logic [N_SOURCES-1:0]  eligible;
   logic [N_SOURCES-1:0]  ack_clr;
   logic [N_SOURCES-1:0]  miss_set;
   logic [ID_W-1:0]       irq_id_q;
   logic [ID_W-1:0]       sel_ptr;
   logic [ID_W-1:0]       sel_idx;
   logic                  sel_found;
   logic                  ack_fire;
   logic                  load_offer;

   // Masking only gates delivery; pending captures every request.
   assign eligible = pending_q & int_mask;

`ifdef INT_CTRL_ROUND_ROBIN_EN
   logic [ID_W-1:0] rr_ptr_q;

   // Remember the last acknowledged source; reset value makes the first scan start at 0.
   always_ff @(posedge clk) begin
      if (!rst_n)        rr_ptr_q <= ID_W'(N_SOURCES - 1);
      else if (ack_fire) rr_ptr_q <= irq_id_q;
   end

   assign sel_ptr = rr_ptr_q;
`else
   assign sel_ptr = '0;
`endif

   int_priority_select #(
      .N_SOURCES (N_SOURCES),
      .ID_W      (ID_W)
   ) u_select (
      .eligible (eligible),
      .ptr      (sel_ptr),
      .found    (sel_found),
      .idx      (sel_idx)
   );

   // Next-state and strobes for the delivery FSM.
   always_comb begin
      state_nxt  = state_q;
      load_offer = 1'b0;
      ack_fire   = 1'b0;
      case (state_q)
         IDLE: begin
            if (global_int_en && sel_found) begin
               state_nxt  = REQUEST;
               load_offer = 1'b1;
            end
         end
         REQUEST: begin
            if (irq_ack) begin
               ack_fire  = 1'b1;
               state_nxt = SERVICE;
            end
         end
         SERVICE: begin
            if (irq_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Decode the acknowledged source into a one-hot clear vector.
   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < N_SOURCES; i++) begin
         ack_clr[i] = ack_fire && (irq_id_q == ID_W'(i));
      end
   end

   // A repeat request is "missed" only if it would not be absorbed by the
   // ack-cycle re-set of the same bit.
   assign miss_set = int_req & pending_q & ~ack_clr;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   // Offered id is captured once on entry to REQUEST and held until the next offer.
   always_ff @(posedge clk) begin
      if (!rst_n)          irq_id_q <= '0;
      else if (load_offer) irq_id_q <= sel_idx;
   end

   // Pending and missed bookkeeping; new set events win over clears.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q <= '0;
         missed_q  <= '0;
      end else begin
         pending_q <= (pending_q & ~ack_clr) | int_req;
         missed_q  <= (missed_q & ~{N_SOURCES{missed_clear}}) | miss_set;
      end
   end

   assign irq_valid  = (state_q == REQUEST);
   assign in_service = (state_q == SERVICE);
   assign irq_id     = irq_id_q;
   assign pending    = pending_q;
   assign missed     = missed_q;

endmodule

// File: tb/tb_int_pending_controller.sv
// Directed bench for int_pending_controller: expected offer ids go into a
// queue and a negedge monitor checks each new offer; status checked inline.
// Round-robin expectations apply when INT_CTRL_ROUND_ROBIN_EN is defined.
module tb_int_pending_controller;

   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  int_req;
   logic [N-1:0]  int_mask;
   logic          global_int_en;
   logic          irq_valid;
   logic [IW-1:0] irq_id;
   logic          irq_ack;
   logic          irq_done;
   logic [N-1:0]  pending;
   logic [N-1:0]  missed;
   logic          missed_clear;
   logic          in_service;

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   int_pending_controller #(.N_SOURCES(N), .ID_W(IW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .int_req       (int_req),
      .int_mask      (int_mask),
      .global_int_en (global_int_en),
      .irq_valid     (irq_valid),
      .irq_id        (irq_id),
      .irq_ack       (irq_ack),
      .irq_done      (irq_done),
      .pending       (pending),
      .missed        (missed),
      .missed_clear  (missed_clear),
      .in_service    (in_service)
   );

   always #5 clk = ~clk;

   // Monitor: every new offer pops one expected id; held offers must not change id.
   logic          prev_vld = 1'b0;
   logic [IW-1:0] held_id  = '0;
   always @(negedge clk) begin
      if (irq_valid && !prev_vld) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL offer_unexpected: got id %0d, none expected", irq_id);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(irq_id) != e) begin
               bad++;
               $display("FAIL offer_id: got %0d want %0d", irq_id, e);
            end
         end
         held_id = irq_id;
      end else if (irq_valid && prev_vld) begin
         total++;
         if (irq_id !== held_id) begin
            bad++;
            $display("FAIL offer_stable: got %0d want %0d", irq_id, held_id);
         end
      end
      prev_vld = irq_valid;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Queue the expected id, then wait (bounded) for the offer to appear.
   task automatic wait_offer(input int id, input int budget);
      int n;
      exp_q.push_back(id);
      n = 0;
      while (!irq_valid && n < budget) begin
         cyc();
         n++;
      end
      total++;
      if (!irq_valid) begin
         bad++;
         $display("FAIL offer_timeout: got no offer after %0d cycles, want id %0d", n, id);
      end
   endtask

   // Acknowledge the current offer, then finish the handler.
   task automatic ack_done();
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      chk("ack_in_service", in_service, 1);
      chk("ack_valid_drop", irq_valid, 0);
      irq_done = 1'b1;
      cyc();
      irq_done = 1'b0;
      chk("done_in_service", in_service, 0);
   endtask

   task automatic pulse(input logic [N-1:0] v);
      int_req = v;
      cyc();
      int_req = '0;
   endtask

   initial begin
      rst_n = 1'b0; int_req = '0; int_mask = 4'hF; global_int_en = 1'b1;
      irq_ack = 1'b0; irq_done = 1'b0; missed_clear = 1'b0;
      int_req = 4'b1111;                       // dropped during reset
      cyc(); cyc();
      int_req = '0;
      cyc();
      chk("rst_valid",   irq_valid, 0);
      chk("rst_id",      irq_id, 0);
      chk("rst_pending", pending, 0);
      chk("rst_missed",  missed, 0);
      chk("rst_insvc",   in_service, 0);
      rst_n = 1'b1;
      cyc();
      chk("post_rst_pending", pending, 0);

      // Single request, two-cycle latency.
      pulse(4'b0100);
      chk("single_pending", pending, 4'b0100);
      chk("single_not_yet", irq_valid, 0);
      wait_offer(2, 1);
      chk("single_id", irq_id, 2);
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      chk("single_ack_pending", pending, 0);
      chk("single_ack_insvc", in_service, 1);
      irq_done = 1'b1;
      cyc();
      irq_done = 1'b0;
      chk("single_done_insvc", in_service, 0);

      // Simultaneous requests; round-robin pointer sits at 2 here.
      pulse(4'b1010);
`ifdef INT_CTRL_ROUND_ROBIN_EN
      wait_offer(3, 4); ack_done();
      wait_offer(1, 4); ack_done();
`else
      wait_offer(1, 4); ack_done();
      wait_offer(3, 4); ack_done();
`endif
      // Serve 3 alone, then 1010 again: both builds give 1 then 3.
      pulse(4'b1000);
      wait_offer(3, 4); ack_done();
      pulse(4'b1010);
      wait_offer(1, 4); ack_done();
      wait_offer(3, 4); ack_done();

      // Masked source stays pending without an offer.
      int_mask = 4'b1110;
      pulse(4'b0001);
      chk("mask_pending", pending, 4'b0001);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("mask_no_offer", irq_valid, 0);
      end
      int_mask = 4'hF;
      wait_offer(0, 2);
      ack_done();

      // Missed detection and set-wins on the ack cycle.
      pulse(4'b0001);
      exp_q.push_back(0);
      int_req = 4'b0001;
      cyc();
      int_req = '0;
      chk("missed_set", missed, 4'b0001);
      chk("missed_offer", irq_valid, 1);
      missed_clear = 1'b1;
      cyc();
      missed_clear = 1'b0;
      chk("missed_clr", missed, 0);
      irq_ack = 1'b1; int_req = 4'b0001;
      cyc();
      irq_ack = 1'b0; int_req = '0;
      chk("setwins_pending", pending, 4'b0001);
      chk("setwins_missed", missed, 0);
      chk("setwins_insvc", in_service, 1);
      irq_done = 1'b1;
      cyc();
      irq_done = 1'b0;
      wait_offer(0, 2);
      // New missed event beats a same-cycle clear.
      int_req = 4'b0001; missed_clear = 1'b1;
      cyc();
      int_req = '0; missed_clear = 1'b0;
      chk("clr_vs_set", missed, 4'b0001);
      missed_clear = 1'b1;
      cyc();
      missed_clear = 1'b0;
      chk("clr_after", missed, 0);
      ack_done();

      // Stray ack/done outside their states are ignored.
      irq_ack = 1'b1; irq_done = 1'b1;
      cyc();
      irq_ack = 1'b0; irq_done = 1'b0;
      chk("stray_valid", irq_valid, 0);
      chk("stray_insvc", in_service, 0);

      // Reset in the middle of an offer.
      pulse(4'b0110);
      wait_offer(1, 2);
      chk("mid_pending", pending, 4'b0110);
      rst_n = 1'b0; irq_ack = 1'b1; int_req = 4'b1000;
      cyc();
      chk("midrst_valid",   irq_valid, 0);
      chk("midrst_id",      irq_id, 0);
      chk("midrst_pending", pending, 0);
      chk("midrst_missed",  missed, 0);
      chk("midrst_insvc",   in_service, 0);
      cyc();
      rst_n = 1'b1; irq_ack = 1'b0; int_req = '0;
      cyc(); cyc();
      chk("after_rst_valid",   irq_valid, 0);
      chk("after_rst_pending", pending, 0);

      // Reset while a handler runs.
      pulse(4'b0010);
      wait_offer(1, 2);
      irq_ack = 1'b1;
      cyc();
      irq_ack = 1'b0;
      chk("svc_insvc", in_service, 1);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("svcrst_insvc", in_service, 0);
      cyc();
      chk("svcrst_valid", irq_valid, 0);

      cyc();
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/int_pending_controller.md
INT_PENDING_CONTROLLER -- requirements
Module: int_pending_controller

Interface
REQ-001 SHALL have parameter N_SOURCES, default 4: number of interrupt sources; legal range 2..16.
REQ-002 SHALL have parameter ID_W, default $clog2(N_SOURCES): width of the source index.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port int_req  input  N_SOURCES  single-cycle request pulses from edge-detect handlers.
REQ-006 SHALL have port int_mask  input  N_SOURCES  per-source enable (1 = eligible for delivery).
REQ-007 SHALL have port global_int_en  input  1  global delivery enable.
REQ-008 SHALL have port irq_valid  output  1  interrupt offered to CPU.
REQ-009 SHALL have port irq_id  output  ID_W  index of offered source.
REQ-010 SHALL have port irq_ack  input  1  CPU accepts offered interrupt.
REQ-011 SHALL have port irq_done  input  1  CPU finished handler (return-from-interrupt pulse).
REQ-012 SHALL have port pending  output  N_SOURCES  latched, not-yet-acknowledged requests.
REQ-013 SHALL have port missed  output  N_SOURCES  sticky: request arrived while same source already pending.
REQ-014 SHALL have port missed_clear  input  1  clears all missed bits.
REQ-015 SHALL have port in_service  output  1  high while a handler is running.

Function
REQ-016 SHALL set pending[i] the cycle after int_req[i]=1, regardless of mask or global enable.
REQ-017 SHALL set missed[i] the cycle after int_req[i]=1 while pending[i]=1 already.
REQ-018 SHALL implement states IDLE, REQUEST, SERVICE.
REQ-019 IDLE: if global_int_en=1 and (pending & int_mask)!=0, SHALL go to REQUEST, registering irq_id = selected source and irq_valid=1 next cycle.
REQ-020 Fixed priority: lowest index among eligible pending bits SHALL be selected.
REQ-021 REQUEST: irq_valid and irq_id SHALL hold stable until irq_ack=1, unaffected by later mask/global_int_en changes.
REQ-022 On irq_valid & irq_ack SHALL clear pending[irq_id], drop irq_valid, assert in_service, enter SERVICE next cycle.
REQ-023 Same-cycle ack and int_req[irq_id]: set SHALL win; pending[irq_id] stays 1, missed unchanged.
REQ-024 SERVICE: no new offer; on irq_done=1 SHALL return to IDLE and drop in_service next cycle.
REQ-025 irq_done outside SERVICE and irq_ack outside REQUEST SHALL be ignored.
REQ-026 missed_clear SHALL clear all missed bits; same-cycle new missed event SHALL win for that bit.
REQ-027 Minimum latency int_req pulse to irq_valid SHALL be 2 cycles (pending capture, then offer).

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, irq_valid=0, irq_id=0, pending=0, missed=0, in_service=0, including mid-REQUEST or mid-SERVICE.
REQ-029 int_req pulses during reset SHALL be dropped.

Configuration
REQ-030 Macro INT_CTRL_ROUND_ROBIN_EN defined: selection SHALL be round-robin, searching upward (wrapping) from last-acknowledged index + 1; pointer resets to N_SOURCES-1 so first search starts at 0.
REQ-031 Macro undefined: fixed priority per REQ-020, no pointer register.

Structure
REQ-032 Package int_ctrl_pkg SHALL hold the state enum typedef (IDLE/REQUEST/SERVICE) and the max-sources constant 16.
REQ-033 Sub-module int_priority_select SHALL be combinational: inputs eligible vector and pointer, outputs found flag and index; pointer input unused when fixed priority.

Verification
REQ-034 Single request: int_req=4'b0100 one cycle, mask=4'hF, global=1 -> pending=4'b0100 at +1, irq_valid=1 with irq_id=2 at +2; ack -> pending=0, in_service=1; irq_done -> IDLE.
REQ-035 Simultaneous: int_req=4'b1010 -> irq_id=1 first; after ack+done, irq_id=3 (fixed); round-robin build: after serving 3, new 4'b1010 -> irq_id=1 again, after serving 1 -> irq_id=3.
REQ-036 Masking: int_req=4'b0001 with int_mask=4'b1110 -> pending=4'b0001, irq_valid stays 0; set mask bit0 -> irq_valid=1, irq_id=0 two cycles later at most.
REQ-037 Missed/set-wins: second int_req[0] while pending[0]=1 -> missed=4'b0001; int_req[0] on ack cycle -> pending[0] remains 1; missed_clear -> missed=0.
REQ-038 Reset mid-operation: rst_n=0 during REQUEST with pending=4'b0110 -> all outputs 0, state IDLE next cycle; irq_ack during reset has no effect.
